// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// Two-to-one AXI4 read arbiter (LSU fixed priority), one outstanding read, response routed to owner.
// Latency: grant cycle N, downstream arvalid from N+1; R backpressure passes straight through, no buffering.
module ysyx_23060025_axi_rd_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    input  logic [ADDR_LEN-1:0] lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [ADDR_LEN-1:0] io_master_araddr,
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [3:0]          io_master_arid,
    input  logic [DATA_LEN-1:0] io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic                io_master_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_LEN-1:0] araddr_q, araddr_d;
    logic [3:0]          arid_q, arid_d;

    logic grant_lsu;
    logic grant_ifu;
    logic in_r;

    assign grant_lsu = (state_q == IDLE) && lsu_arvalid;
    assign grant_ifu = (state_q == IDLE) && !lsu_arvalid && ifu_arvalid;
    assign in_r      = (state_q == R);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        case (state_q)
            IDLE: begin
                if (grant_lsu || grant_ifu) begin
                    owner_d  = grant_lsu;
                    araddr_d = grant_lsu ? lsu_araddr : ifu_araddr;
                    arid_d   = {3'b000, grant_lsu};
                    state_d  = AR;
                end
            end
            AR: begin
                if (io_master_arready) begin
                    state_d = R;
                end
            end
            R: begin
                // Only the rlast beat closes the transaction; earlier burst beats stay in R.
                if (io_master_rvalid && io_master_rready && io_master_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            araddr_q <= '0;
            arid_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
        end
    end

    assign ifu_arready       = grant_ifu;
    assign lsu_arready       = grant_lsu;
    assign io_master_arvalid = (state_q == AR);
    assign io_master_araddr  = araddr_q;
    assign io_master_arid    = arid_q;
    assign io_master_rready  = in_r && (owner_q ? lsu_rready : ifu_rready);

    // Data/resp are broadcast ungated; each master qualifies them with its own rvalid.
    assign ifu_rvalid = in_r && !owner_q && io_master_rvalid;
    assign lsu_rvalid = in_r &&  owner_q && io_master_rvalid;
    assign ifu_rdata  = io_master_rdata;
    assign lsu_rdata  = io_master_rdata;
    assign ifu_rresp  = io_master_rresp;
    assign lsu_rresp  = io_master_rresp;

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
// Bench for the AXI read arbiter: directed transactions, scoreboard queues drained by a negedge monitor.
module tb_ysyx_23060025_axi_rd_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] io_master_araddr;
    logic        io_master_arvalid;
    logic        io_master_arready;
    logic [3:0]  io_master_arid;
    logic [31:0] io_master_rdata;
    logic [1:0]  io_master_rresp;
    logic        io_master_rvalid;
    logic        io_master_rready;
    logic        io_master_rlast;

    ysyx_23060025_axi_rd_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .ifu_araddr        (ifu_araddr),
        .ifu_arvalid       (ifu_arvalid),
        .ifu_arready       (ifu_arready),
        .ifu_rdata         (ifu_rdata),
        .ifu_rresp         (ifu_rresp),
        .ifu_rvalid        (ifu_rvalid),
        .ifu_rready        (ifu_rready),
        .lsu_araddr        (lsu_araddr),
        .lsu_arvalid       (lsu_arvalid),
        .lsu_arready       (lsu_arready),
        .lsu_rdata         (lsu_rdata),
        .lsu_rresp         (lsu_rresp),
        .lsu_rvalid        (lsu_rvalid),
        .lsu_rready        (lsu_rready),
        .io_master_araddr  (io_master_araddr),
        .io_master_arvalid (io_master_arvalid),
        .io_master_arready (io_master_arready),
        .io_master_arid    (io_master_arid),
        .io_master_rdata   (io_master_rdata),
        .io_master_rresp   (io_master_rresp),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rready  (io_master_rready),
        .io_master_rlast   (io_master_rlast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // {arid, araddr} expected on each downstream AR handshake
    logic [35:0] exp_ar[$];
    // {owner, rresp, rdata} expected on each upstream R handshake
    logic [34:0] exp_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic pop_r(input string name, input logic [34:0] act);
        logic [34:0] e;
        if (exp_r.size() == 0) begin
            n_total++;
            $display("FAIL %s: unexpected beat 0x%0h, nothing expected", name, act);
        end else begin
            e = exp_r.pop_front();
            chk(name, {29'd0, act}, {29'd0, e});
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (io_master_arvalid && io_master_arready) begin
                if (exp_ar.size() == 0) begin
                    n_total++;
                    $display("FAIL ar_hs: unexpected 0x%0h, nothing expected", {io_master_arid, io_master_araddr});
                end else begin
                    logic [35:0] e;
                    e = exp_ar.pop_front();
                    chk("ar_hs", {28'd0, io_master_arid, io_master_araddr}, {28'd0, e});
                end
            end
            if (ifu_rvalid && ifu_rready) pop_r("ifu_r", {1'b0, ifu_rresp, ifu_rdata});
            if (lsu_rvalid && lsu_rready) pop_r("lsu_r", {1'b1, lsu_rresp, lsu_rdata});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Caller has already raised the master's arvalid; waits for arready, then drops arvalid.
    task automatic grant(input bit who, input logic [31:0] addr, output int waited);
        int n;
        n = 0;
        #1;
        while (!(who ? lsu_arready : ifu_arready) && n < 20) begin
            step();
            n++;
        end
        chk("grant_arready", who ? lsu_arready : ifu_arready, 1);
        chk("grant_other_arready", who ? ifu_arready : lsu_arready, 0);
        chk("grant_no_arvalid_yet", io_master_arvalid, 0);
        exp_ar.push_back({3'b000, who, addr});
        waited = n;
        step();
        if (who) lsu_arvalid = 1'b0;
        else ifu_arvalid = 1'b0;
    endtask

    task automatic slave_ar(input bit who, input logic [31:0] addr, input int stall);
        for (int i = 0; i <= stall; i++) begin
            io_master_arready = (i == stall);
            #1;
            chk("ar_arvalid", io_master_arvalid, 1);
            chk("ar_addr", io_master_araddr, addr);
            chk("ar_id", io_master_arid, {3'b000, who});
            chk("ar_no_upstream_ready", {ifu_arready, lsu_arready}, 0);
            step();
        end
        io_master_arready = 1'b0;
    endtask

    task automatic set_rready(input bit who, input logic v);
        if (who) lsu_rready = v;
        else ifu_rready = v;
    endtask

    task automatic slave_r(input bit who, input logic [31:0] data, input logic [1:0] resp, input int stall);
        io_master_rvalid = 1'b1;
        io_master_rdata  = data;
        io_master_rresp  = resp;
        io_master_rlast  = 1'b1;
        for (int i = 0; i <= stall; i++) begin
            set_rready(who, i == stall);
            if (i == stall) exp_r.push_back({who, resp, data});
            #1;
            chk("r_owner_rvalid", who ? lsu_rvalid : ifu_rvalid, 1);
            chk("r_other_rvalid", who ? ifu_rvalid : lsu_rvalid, 0);
            chk("r_master_rready", io_master_rready, i == stall);
            chk("r_no_upstream_ready", {ifu_arready, lsu_arready}, 0);
            step();
        end
        io_master_rvalid = 1'b0;
        io_master_rlast  = 1'b0;
        set_rready(who, 1'b0);
        #1;
        chk("idle_arvalid", io_master_arvalid, 0);
        chk("idle_rready", io_master_rready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        reset = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
        io_master_arready = 1'b0; io_master_rdata = '0; io_master_rresp = '0;
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_arvalid", io_master_arvalid, 0);
        chk("rst_araddr", io_master_araddr, 0);
        chk("rst_arid", io_master_arid, 0);
        chk("rst_rready", io_master_rready, 0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // IFU-only fetch
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        grant(1'b0, 32'h8000_0000, w);
        chk("t1_grant_wait", w, 0);
        slave_ar(1'b0, 32'h8000_0000, 0);
        slave_r(1'b0, 32'h0000_0413, 2'b00, 0);

        // Simultaneous requests: LSU first, IFU right after
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
        grant(1'b1, 32'h8000_1000, w);
        chk("t2_lsu_wait", w, 0);
        slave_ar(1'b1, 32'h8000_1000, 0);
        slave_r(1'b1, 32'h1111_1111, 2'b00, 0);
        grant(1'b0, 32'h8000_0004, w);
        chk("t2_ifu_wait", w, 0);
        slave_ar(1'b0, 32'h8000_0004, 0);
        slave_r(1'b0, 32'h2222_2222, 2'b00, 0);

        // LSU holds rready low for 3 cycles
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1004;
        grant(1'b1, 32'h8000_1004, w);
        slave_ar(1'b1, 32'h8000_1004, 0);
        slave_r(1'b1, 32'h3333_3333, 2'b00, 3);

        // Slave stalls arready for 4 cycles
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0008;
        grant(1'b0, 32'h8000_0008, w);
        slave_ar(1'b0, 32'h8000_0008, 4);
        slave_r(1'b0, 32'h4444_4444, 2'b00, 0);

        // Error responses forwarded unchanged
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000;
        grant(1'b1, 32'h8000_2000, w);
        slave_ar(1'b1, 32'h8000_2000, 0);
        slave_r(1'b1, 32'hDEAD_BEEF, 2'b10, 0);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_000C;
        grant(1'b0, 32'h8000_000C, w);
        chk("t5_next_grant_wait", w, 0);
        slave_ar(1'b0, 32'h8000_000C, 1);
        slave_r(1'b0, 32'h5555_5555, 2'b11, 0);

        // Asynchronous reset while in R
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0020;
        grant(1'b0, 32'h8000_0020, w);
        slave_ar(1'b0, 32'h8000_0020, 0);
        io_master_rvalid = 1'b1; io_master_rdata = 32'h6666_6666; io_master_rlast = 1'b1;
        ifu_rready = 1'b1;
        #1;
        chk("t6_pre_rst_rready", io_master_rready, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_ifu_rvalid", ifu_rvalid, 0);
        chk("t6_rst_rready", io_master_rready, 0);
        chk("t6_rst_arvalid", io_master_arvalid, 0);
        chk("t6_rst_araddr", io_master_araddr, 0);
        chk("t6_rst_arid", io_master_arid, 0);
        io_master_rvalid = 1'b0; io_master_rlast = 1'b0; ifu_rready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        step();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0010;
        grant(1'b0, 32'h8000_0010, w);
        chk("t6_fresh_grant_wait", w, 0);
        slave_ar(1'b0, 32'h8000_0010, 0);
        slave_r(1'b0, 32'h0010_0073, 2'b00, 0);

        repeat (2) step();
        chk("ar_queue_drained", exp_ar.size(), 0);
        chk("r_queue_drained", exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
